// File: rtl/eth_rx_param.sv
// eth_rx_param: RMII/MII Ethernet receiver; deframes MAC header, streams payload, checks FCS.
// Define ETH_RX_PARAM_MAC_FILTER_EN to drop frames not addressed to MAC_ADDR or broadcast.

module eth_rx_param #(
   parameter int          SYM_WIDTH     = 2,
   parameter int          MAX_FRAME_LEN = 1518,
   parameter logic [47:0] MAC_ADDR      = 48'h02_00_00_00_00_01
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inclk,
   input  logic [SYM_WIDTH-1:0] in,
   input  logic                 downstream_done,
   output logic                 outclk,
   output logic [7:0]           out,
   output logic                 ethertype_outclk,
   output logic [15:0]          ethertype_out,
   output logic [10:0]          len_out,
   output logic                 err,
   output logic [2:0]           err_code,
   output logic                 done
);

   localparam int          SPB      = 8 / SYM_WIDTH;
   localparam logic [31:0] CRC_POLY = 32'hEDB88320;
`ifdef ETH_RX_PARAM_MAC_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   localparam logic [2:0] E_BREAK    = 3'd1;
   localparam logic [2:0] E_OVERLEN  = 3'd2;
   localparam logic [2:0] E_CRC      = 3'd3;
   localparam logic [2:0] E_TRAILING = 3'd4;
   localparam logic [2:0] E_FILTER   = 3'd5;

   generate
      if (SYM_WIDTH != 2 && SYM_WIDTH != 4) begin : g_bad_sym_width
         $error("eth_rx_param: SYM_WIDTH must be 2 or 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_MAC_DST, S_MAC_SRC, S_ETHERTYPE, S_PAYLOAD, S_CRC, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sym_cnt_q, sym_cnt_d;
   logic [2:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] total_q, total_d;
   logic [7:0]  acc_q, acc_d;
   logic [31:0] crc_q, crc_d;
   logic        idle_q, idle_d;
   logic [10:0] pay_cnt_q, pay_cnt_d;
   logic [7:0]  eth_hi_q, eth_hi_d;
   logic [15:0] eth_q, eth_d;
   logic        good_q, good_d;
   logic        dst_match_q, dst_match_d;
   logic        dst_bcast_q, dst_bcast_d;

   logic        bclk;
   logic [7:0]  byte_w;
   logic [47:0] mac_sh;
   logic        overlen, crc_bad, trailing, filt_miss, fcs_last;

   // Reflected CRC-32, one bit-step per symbol bit, LSB first.
   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [SYM_WIDTH-1:0] s);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < SYM_WIDTH; i++) begin
         r = (r[0] ^ s[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
      end
      return r;
   endfunction

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d     = state_q;
      sym_cnt_d   = sym_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      total_d     = total_q;
      acc_d       = acc_q;
      crc_d       = crc_q;
      idle_d      = idle_q;
      pay_cnt_d   = pay_cnt_q;
      eth_hi_d    = eth_hi_q;
      eth_d       = eth_q;
      good_d      = good_q;
      dst_match_d = dst_match_q;
      dst_bcast_d = dst_bcast_q;

      byte_w           = {in, acc_q[7:SYM_WIDTH]};
      bclk             = inclk && (sym_cnt_q == 2'(SPB - 1));
      mac_sh           = MAC_ADDR << {byte_cnt_q, 3'b000};
      outclk           = 1'b0;
      out              = byte_w;
      ethertype_outclk = 1'b0;
      ethertype_out    = eth_q;
      len_out          = pay_cnt_q;
      err              = 1'b0;
      err_code         = 3'd0;
      done             = 1'b0;
      overlen          = 1'b0;
      crc_bad          = 1'b0;
      trailing         = 1'b0;
      filt_miss        = 1'b0;
      fcs_last         = 1'b0;

      if (!inclk) begin
         if (!idle_q) begin
            err      = 1'b1;
            err_code = E_BREAK;
         end
         // len_out and ethertype_out stay readable after the frame; they clear on the next start.
         state_d     = S_MAC_DST;
         sym_cnt_d   = '0;
         byte_cnt_d  = '0;
         total_d     = '0;
         acc_d       = '0;
         crc_d       = '1;
         idle_d      = 1'b1;
         good_d      = 1'b0;
         dst_match_d = 1'b1;
         dst_bcast_d = 1'b1;
      end else begin
         sym_cnt_d = bclk ? 2'd0 : sym_cnt_q + 2'd1;
         acc_d     = byte_w;
         if (idle_q && state_q == S_MAC_DST) begin
            pay_cnt_d = '0;
            eth_d     = '0;
         end
         if (bclk && state_q != S_DONE) begin
            if (total_q >= 16'(MAX_FRAME_LEN)) overlen = 1'b1;
            else                               total_d = total_q + 16'd1;
         end

         case (state_q)
            S_MAC_DST: begin
               crc_d = crc_step(crc_q, in);
               if (bclk) begin
                  dst_match_d = dst_match_q && (byte_w == mac_sh[47:40]);
                  dst_bcast_d = dst_bcast_q && (byte_w == 8'hFF);
                  byte_cnt_d  = byte_cnt_q + 3'd1;
                  if (byte_cnt_q == 3'd5) begin
                     byte_cnt_d = '0;
                     state_d    = S_MAC_SRC;
                     filt_miss  = FILTER_EN && !dst_match_d && !dst_bcast_d;
                  end
               end
            end
            S_MAC_SRC: begin
               crc_d = crc_step(crc_q, in);
               if (bclk) begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
                  if (byte_cnt_q == 3'd5) begin
                     byte_cnt_d = '0;
                     state_d    = S_ETHERTYPE;
                  end
               end
            end
            S_ETHERTYPE: begin
               crc_d = crc_step(crc_q, in);
               if (bclk) begin
                  if (byte_cnt_q == 3'd0) begin
                     eth_hi_d   = byte_w;
                     byte_cnt_d = 3'd1;
                  end else begin
                     ethertype_outclk = 1'b1;
                     eth_d            = {eth_hi_q, byte_w};
                     ethertype_out    = {eth_hi_q, byte_w};
                     byte_cnt_d       = '0;
                     state_d          = S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               crc_d = crc_step(crc_q, in);
               if (bclk) begin
                  outclk = 1'b1;
                  if (pay_cnt_q != 11'h7FF) pay_cnt_d = pay_cnt_q + 11'd1;
                  if (downstream_done) state_d = S_CRC;
               end
            end
            S_CRC: begin
               // The residue is consumed as the expected FCS, one symbol at a time.
               crc_bad = (in != ~crc_q[SYM_WIDTH-1:0]);
               crc_d   = {{SYM_WIDTH{1'b1}}, crc_q[31:SYM_WIDTH]};
               if (bclk) begin
                  byte_cnt_d = byte_cnt_q + 3'd1;
                  if (byte_cnt_q == 3'd3) begin
                     byte_cnt_d = '0;
                     fcs_last   = 1'b1;
                     state_d    = S_DONE;
                  end
               end
            end
            S_DONE:  trailing = good_q && (in != '0);
            default: state_d = S_DONE;
         endcase

         if (overlen || crc_bad || trailing || filt_miss) begin
            err              = 1'b1;
            err_code         = overlen ? E_OVERLEN : crc_bad ? E_CRC : trailing ? E_TRAILING : E_FILTER;
            state_d          = S_DONE;
            good_d           = 1'b0;
            outclk           = 1'b0;
            ethertype_outclk = 1'b0;
            ethertype_out    = eth_q;
            eth_d            = eth_q;
            pay_cnt_d        = pay_cnt_q;
         end else if (fcs_last) begin
            done   = 1'b1;
            good_d = 1'b1;
         end
         idle_d = (state_d == S_DONE);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_MAC_DST;
         sym_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         total_q     <= '0;
         acc_q       <= '0;
         crc_q       <= '1;
         idle_q      <= 1'b1;
         pay_cnt_q   <= '0;
         eth_hi_q    <= '0;
         eth_q       <= '0;
         good_q      <= 1'b0;
         dst_match_q <= 1'b1;
         dst_bcast_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         sym_cnt_q   <= sym_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         total_q     <= total_d;
         acc_q       <= acc_d;
         crc_q       <= crc_d;
         idle_q      <= idle_d;
         pay_cnt_q   <= pay_cnt_d;
         eth_hi_q    <= eth_hi_d;
         eth_q       <= eth_d;
         good_q      <= good_d;
         dst_match_q <= dst_match_d;
         dst_bcast_q <= dst_bcast_d;
      end
   end

endmodule
